uart_tx_fifo: RTL and testbench

- Buffered 8N1 UART transmitter: the transmit direction paired with the existing receiver path.
- Accepts bytes on a one-cycle strobe (e.g. the receiver's RX_Done_Sig/RX_Data for echo).
- Queues them in a small FIFO and serializes each byte LSB-first on TX_Pin_Out at a fixed bit period.
- Reports per-byte completion, busy, ready and a sticky overflow flag, so the top level can drive a real TX enable/done handshake.

---
 rtl/uart_tx_fifo_pkg.sv | 27 ++
 rtl/uart_tx_fifo_sync_fifo.sv | 75 +++++++
 rtl/uart_tx_fifo.sv | 152 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_pkg
//   Shared definitions for the buffered 8N1 UART transmitter. It holds the FSM
//   state encoding, the default bit period and FIFO depth, and the frame shape
//   constants (data bits and stop bits).
//   Ports: none (package).
// -----------------------------------------------------------------------------
package uart_tx_fifo_pkg;

  // Transmit FSM states. The encodings are fixed so that logic analyser and
  // debug tooling can decode the state register directly.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // 50 MHz system clock at 115200 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int DEFAULT_FIFO_DEPTH   = 8;

  // Frame shape: 8 data bits, no parity, 1 stop bit.
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

endpackage : uart_tx_fifo_pkg

// File: rtl/uart_tx_fifo_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with first-word fall-through read data. A write is taken
//   when the FIFO is not full, or when it is full and a read happens in the
//   same cycle. Reads of an empty FIFO are ignored. Both pointers wrap modulo
//   DEPTH, which must be a power of two.
//   Ports:
//     clk     in   clock, rising edge
//     rst     in   synchronous active-high reset (empties the FIFO)
//     wr_en   in   write strobe
//     wr_data in   WIDTH-bit write data
//     rd_en   in   read (pop) strobe
//     rd_data out  WIDTH-bit data at the head of the FIFO
//     full    out  count == DEPTH
//     empty   out  count == 0
//     count   out  number of stored entries, $clog2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A full FIFO can still accept a write when the head leaves in the same cycle.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  assign rd_data = mem[rd_ptr];

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the storage array has no reset; entries are only ever read after
  // being written, so clearing them would add reset fan-out for nothing.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule : sync_fifo

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Buffered 8N1 UART transmitter. Bytes strobed in on TX_En_Sig are queued
//   in a FIFO and sent LSB first on TX_Pin_Out, CLKS_PER_BIT clocks per bit.
//   Ports:
//     CLK          in   system clock, rising edge
//     RST          in   synchronous active-high reset, aborts any frame
//     TX_En_Sig    in   write strobe for TX_Data
//     TX_Data      in   byte to enqueue (ignored while TX_En_Sig=0)
//     TX_Ready     out  FIFO has a free slot
//     TX_Busy      out  a frame is in progress or bytes are waiting
//     TX_Done_Sig  out  one-cycle pulse on the last cycle of each stop bit
//     TX_Overflow  out  sticky: a write was dropped since the last reset
//     TX_Pin_Out   out  registered serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TX_En_Sig,
  input  logic [7:0] TX_Data,
  output logic       TX_Ready,
  output logic       TX_Busy,
  output logic       TX_Done_Sig,
  output logic       TX_Overflow,
  output logic       TX_Pin_Out
);

  localparam int BW  = $clog2(CLKS_PER_BIT);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int BIW = $clog2(DATA_BITS);

  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BIW-1:0] LAST_DATA = BIW'(DATA_BITS - 1);
  localparam logic [BIW-1:0] LAST_STOP = BIW'(STOP_BITS - 1);

  tx_state_e       state;
  tx_state_e       state_next;
  logic [BW-1:0]   baud;
  logic [BIW-1:0]  bit_idx;
  logic [7:0]      shift;
  logic            line_q;
  logic            line_next;
  logic            overflow_q;
  logic            baud_last;
  logic            pop;
  logic            drop;

  logic [7:0]      fifo_data;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .wr_en   (TX_En_Sig),
    .wr_data (TX_Data),
    .rd_en   (pop),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign baud_last = (baud == BAUD_LAST);

  // A write is lost only when the FIFO is full and no byte leaves this cycle.
  assign drop = TX_En_Sig && fifo_full && !pop;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!fifo_empty) state_next = START;
      START:   if (baud_last) state_next = DATA;
      DATA:    if (baud_last && bit_idx == LAST_DATA) state_next = STOP;
      STOP:    if (baud_last && bit_idx == LAST_STOP) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. line_next feeds the line register, so the pin trails the
  // state by one clock; every bit still lasts exactly CLKS_PER_BIT cycles.
  // ---------------------------------------------------------------------------
  always_comb begin
    pop         = 1'b0;
    line_next   = 1'b1;
    TX_Done_Sig = 1'b0;
    case (state)
      IDLE:    pop = !fifo_empty;
      START:   line_next = 1'b0;
      DATA:    line_next = shift[0];
      STOP:    TX_Done_Sig = baud_last && (bit_idx == LAST_STOP);
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: baud counter, bit counter, shift register, line, overflow flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      baud       <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      line_q     <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      // Held at zero in IDLE so each frame starts with a full-length start bit;
      // every other state change coincides with baud_last.
      if (state == IDLE || baud_last) baud <= '0;
      else                            baud <= baud + 1'b1;

      if (state_next != state) bit_idx <= '0;
      else if (baud_last)      bit_idx <= bit_idx + 1'b1;

      if (pop)                            shift <= fifo_data;
      else if (state == DATA && baud_last) shift <= shift >> 1;

      line_q <= line_next;

      if (drop) overflow_q <= 1'b1;
    end
  end

  assign TX_Pin_Out  = line_q;
  assign TX_Overflow = overflow_q;
  assign TX_Ready    = (fifo_count < CW'(FIFO_DEPTH));
  assign TX_Busy     = (state != IDLE) || !fifo_empty;

endmodule : uart_tx_fifo

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Directed self-checking bench for uart_tx_fifo with CLKS_PER_BIT=4 and
//   FIFO_DEPTH=4. A behavioural 8N1 receiver decodes TX_Pin_Out so that whole
//   byte sequences can be compared against the bytes that were written.
//   Cycle indices in comments: "edge N" is the rising edge on which a write
//   strobe is sampled; outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB + 1;  // cycles per byte back to back

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       TX_En_Sig = 1'b0;
  logic [7:0] TX_Data = 8'h00;
  logic       TX_Ready;
  logic       TX_Busy;
  logic       TX_Done_Sig;
  logic       TX_Overflow;
  logic       TX_Pin_Out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  bit rx_enable = 1'b0;

  logic [7:0] rx_byte [$];
  int         rx_cyc  [$];
  bit         rx_ok   [$];

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .TX_En_Sig   (TX_En_Sig),
    .TX_Data     (TX_Data),
    .TX_Ready    (TX_Ready),
    .TX_Busy     (TX_Busy),
    .TX_Done_Sig (TX_Done_Sig),
    .TX_Overflow (TX_Overflow),
    .TX_Pin_Out  (TX_Pin_Out)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) if (TX_Done_Sig === 1'b1) done_cnt <= done_cnt + 1;

  // Receiver model: detects the start bit, samples each bit near its middle,
  // records the byte, the edge index of the falling start edge and framing.
  initial begin : rx_model
    logic [7:0] b;
    int         t0;
    bit         ok;
    forever begin
      @(negedge CLK);
      if (rx_enable && TX_Pin_Out === 1'b0) begin
        t0 = cyc;
        ok = 1'b1;
        repeat (CPB / 2) @(negedge CLK);
        if (TX_Pin_Out !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge CLK);
          b[i] = TX_Pin_Out;
        end
        repeat (CPB) @(negedge CLK);
        if (TX_Pin_Out !== 1'b1) ok = 1'b0;
        rx_byte.push_back(b);
        rx_cyc.push_back(t0);
        rx_ok.push_back(ok);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d);
    TX_En_Sig = 1'b1;
    TX_Data   = d;
    tick();
    TX_En_Sig = 1'b0;
    TX_Data   = 8'hxx;
  endtask

  task automatic do_reset(input string tag);
    RST = 1'b1;
    tick();
    check({tag, "_line"},     TX_Pin_Out,  1);
    check({tag, "_done"},     TX_Done_Sig, 0);
    check({tag, "_busy"},     TX_Busy,     0);
    check({tag, "_ready"},    TX_Ready,    1);
    check({tag, "_overflow"}, TX_Overflow, 0);
    RST = 1'b0;
    tick();
  endtask

  task automatic wait_frames(input string tag, input int target, input int budget);
    int n = 0;
    while (rx_byte.size() < target && n < budget) begin
      tick();
      n++;
    end
    check(tag, rx_byte.size(), target);
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int n = 0;
    while (TX_Ready !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, TX_Ready, 1);
  endtask

  logic [7:0] t2 [4] = '{8'h01, 8'h80, 8'hFF, 8'h00};
  logic [7:0] t3 [6] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
  logic [7:0] t4 [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66, 8'hA5};

  initial begin : stimulus
    logic [7:0] d;
    int         base;
    int         dbase;
    int         idx;
    logic       exp_line;
    bit         line_dropped;

    TX_Data = 8'hxx;
    repeat (3) tick();
    do_reset("rst0");
    rx_enable = 1'b1;

    // ---- 1: single 0x55, cycle-exact line / done / busy ---------------------
    d     = 8'h55;
    base  = rx_byte.size();
    dbase = done_cnt;
    write_byte(d);                       // now 1 ns after edge N
    check("t1_k0_busy", TX_Busy, 1);
    check("t1_k0_line", TX_Pin_Out, 1);
    for (int k = 1; k <= 44; k++) begin
      tick();                            // 1 ns after edge N+k
      if (k < 2)       exp_line = 1'b1;  // pop at N+1, line still idle
      else if (k < 6)  exp_line = 1'b0;  // start bit N+2..N+5
      else if (k < 38) begin
        idx      = (k - 6) / 4;
        exp_line = d[idx];
      end
      else             exp_line = 1'b1;  // stop then idle
      check($sformatf("t1_line_k%0d", k), TX_Pin_Out, exp_line);
      check($sformatf("t1_done_k%0d", k), TX_Done_Sig, (k == 40));
      check($sformatf("t1_busy_k%0d", k), TX_Busy, (k <= 40));
    end
    wait_frames("t1_frames", base + 1, 100);
    check("t1_byte", rx_byte[base], 8'h55);
    check("t1_framing", rx_ok[base], 1);
    check("t1_done_count", done_cnt - dbase, 1);

    // ---- 2: burst of four bytes, 41 cycles per frame ------------------------
    base  = rx_byte.size();
    dbase = done_cnt;
    for (int i = 0; i < 4; i++) write_byte(t2[i]);
    wait_frames("t2_frames", base + 4, 4 * FRAME + 50);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_byte%0d", i), rx_byte[base + i], t2[i]);
      check($sformatf("t2_framing%0d", i), rx_ok[base + i], 1);
    end
    for (int i = 1; i < 4; i++)
      check($sformatf("t2_spacing%0d", i), rx_cyc[base + i] - rx_cyc[base + i - 1], FRAME);
    repeat (10) tick();
    check("t2_done_count", done_cnt - dbase, 4);
    check("t2_overflow", TX_Overflow, 0);

    // ---- 3: six writes into an empty FIFO, sixth dropped --------------------
    do_reset("rst3");
    base  = rx_byte.size();
    dbase = done_cnt;
    for (int i = 0; i < 6; i++) begin
      TX_En_Sig = 1'b1;
      TX_Data   = t3[i];
      // First byte pops at once, so the FIFO fills only on the fifth write.
      check($sformatf("t3_ready%0d", i), TX_Ready, (i < 5));
      tick();
    end
    TX_En_Sig = 1'b0;
    TX_Data   = 8'hxx;
    check("t3_overflow_set", TX_Overflow, 1);
    wait_frames("t3_frames", base + 5, 5 * FRAME + 50);
    repeat (2 * FRAME) tick();
    check("t3_frame_total", rx_byte.size(), base + 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("t3_byte%0d", i), rx_byte[base + i], t3[i]);
    check("t3_done_count", done_cnt - dbase, 5);
    check("t3_overflow_sticky", TX_Overflow, 1);

    // ---- 4: write to a full FIFO on the same cycle as a pop -----------------
    do_reset("rst4");
    base = rx_byte.size();
    for (int i = 0; i < 5; i++) write_byte(t4[i]);   // edges N..N+4, full after N+4
    check("t4_full", TX_Ready, 0);
    repeat (37) tick();                              // 1 ns after edge N+41, IDLE
    check("t4_full_before_pop", TX_Ready, 0);
    write_byte(t4[5]);                               // sampled at edge N+42 = pop edge
    check("t4_overflow", TX_Overflow, 0);
    check("t4_still_full", TX_Ready, 0);
    wait_frames("t4_frames", base + 6, 6 * FRAME + 50);
    for (int i = 0; i < 6; i++)
      check($sformatf("t4_byte%0d", i), rx_byte[base + i], t4[i]);
    check("t4_overflow_end", TX_Overflow, 0);

    // ---- 5: reset during DATA bit 3 of 0xC3 ---------------------------------
    do_reset("rst5");
    rx_enable = 1'b0;
    write_byte(8'hC3);                               // edge N
    write_byte(8'h99);                               // edge N+1, stays queued
    repeat (18) tick();                              // 1 ns after edge N+19
    check("t5_bit3_line", TX_Pin_Out, 0);
    check("t5_busy_before", TX_Busy, 1);
    dbase = done_cnt;
    RST = 1'b1;
    tick();                                          // edge N+20
    RST = 1'b0;
    check("t5_line_after", TX_Pin_Out, 1);
    check("t5_done_after", TX_Done_Sig, 0);
    check("t5_busy_after", TX_Busy, 0);
    check("t5_ready_after", TX_Ready, 1);
    line_dropped = 1'b0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      tick();
      if (TX_Pin_Out !== 1'b1) line_dropped = 1'b1;
    end
    check("t5_line_idle", line_dropped, 0);
    check("t5_no_done", done_cnt - dbase, 0);
    rx_enable = 1'b1;
    base = rx_byte.size();
    write_byte(8'h3C);
    wait_frames("t5_frames", base + 1, FRAME + 50);
    repeat (2 * FRAME) tick();
    check("t5_frame_total", rx_byte.size(), base + 1);
    check("t5_byte", rx_byte[base], 8'h3C);
    check("t5_framing", rx_ok[base], 1);
    check("t5_done_count", done_cnt - dbase, 1);

    // ---- 6: loopback stream 0x00..0x0F ---------------------------------------
    base  = rx_byte.size();
    dbase = done_cnt;
    for (int v = 0; v < 16; v++) begin
      wait_ready($sformatf("t6_ready%0d", v), 3 * FRAME);
      write_byte(8'(v));
    end
    wait_frames("t6_frames", base + 16, 16 * FRAME + 100);
    for (int v = 0; v < 16; v++) begin
      check($sformatf("t6_byte%0d", v), rx_byte[base + v], v);
      check($sformatf("t6_framing%0d", v), rx_ok[base + v], 1);
    end
    repeat (10) tick();
    check("t6_done_count", done_cnt - dbase, 16);
    check("t6_busy_end", TX_Busy, 0);
    check("t6_overflow_end", TX_Overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_uart_tx_fifo
